test_divider: RTL and testbench

//  Sequential unsigned integer divider: computes A / B (div) and A % B (mod) by

---
 rtl/test_divider.sv | 105 ++++++++++
 tb/tb_test_divider.sv | 157 +++++++++++++++
 2 files changed

// File: rtl/test_divider.sv
// Sequential unsigned restoring divider: div = A / B, mod = A % B, one quotient bit per clock.
// Optional macro DIV_ZERO_FAST_EN: a zero divisor skips the iterations and finishes on the edge after LOAD.
module test_divider #(
  parameter int unsigned WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  output logic [WIDTH-1:0] mod,
  output logic [WIDTH-1:0] div,
  output logic             done
);

  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_LOAD = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  state_t           state_d;
  logic [WIDTH-1:0] q_q;
  logic [WIDTH-1:0] r_q;
  logic [WIDTH-1:0] b_q;
  logic [CW-1:0]    cnt_q;

  logic [WIDTH:0]   t_c;
  logic             ge_c;
  logic [WIDTH-1:0] r_nx_c;
  logic [WIDTH-1:0] q_nx_c;
  logic             last_c;
  logic             zero_fast_c;

  // One restoring step: shift the next dividend bit into the partial remainder and trial-subtract.
  always_comb begin
    t_c    = {r_q, q_q[WIDTH-1]};
    ge_c   = (t_c >= {1'b0, b_q});
    r_nx_c = ge_c ? WIDTH'(t_c - {1'b0, b_q}) : t_c[WIDTH-1:0];
    q_nx_c = {q_q[WIDTH-2:0], ge_c};
    last_c = (cnt_q == CW'(WIDTH - 1));
`ifdef DIV_ZERO_FAST_EN
    zero_fast_c = (b_q == '0);
`else
    zero_fast_c = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (reset) state_q <= S_LOAD;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_LOAD:  state_d = S_ITER;
      S_ITER:  if (last_c || zero_fast_c) state_d = S_DONE;
      S_DONE:  state_d = S_DONE;
      default: state_d = S_LOAD;
    endcase
  end

  // Datapath and registered results; results only change on the final step.
  always_ff @(posedge clk) begin
    if (reset) begin
      q_q   <= '0;
      r_q   <= '0;
      b_q   <= '0;
      cnt_q <= '0;
      div   <= '0;
      mod   <= '0;
      done  <= 1'b0;
    end else begin
      case (state_q)
        S_LOAD: begin
          q_q   <= A;
          b_q   <= B;
          r_q   <= '0;
          cnt_q <= '0;
        end
        S_ITER: begin
          if (zero_fast_c) begin
            div  <= '1;
            mod  <= q_q;
            done <= 1'b1;
          end else begin
            q_q   <= q_nx_c;
            r_q   <= r_nx_c;
            cnt_q <= cnt_q + CW'(1);
            if (last_c) begin
              div  <= q_nx_c;
              mod  <= r_nx_c;
              done <= 1'b1;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_test_divider.sv
// Scoreboard bench for test_divider: driver queues hand-computed results, monitor checks them when done rises.
module tb_test_divider;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic [7:0] mod;
  logic [7:0] div;
  logic       done;

  test_divider #(.WIDTH(8)) dut (
    .clk  (clk),
    .reset(reset),
    .A    (A),
    .B    (B),
    .mod  (mod),
    .div  (div),
    .done (done)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [7:0] d;
    logic [7:0] m;
    logic [7:0] lat;
  } exp_t;

  exp_t sb[$];
  exp_t cur;
  int   checks = 0;
  int   failures = 0;
  int   edges = 0;
  logic done_q = 1'b0;
  logic mon_en = 1'b0;
  logic have_cur = 1'b0;

  // Edges since the last edge that sampled reset high.
  always @(posedge clk) edges <= reset ? 0 : edges + 1;

  always @(negedge clk) begin
    if (mon_en) begin
      if (done === 1'b1 && done_q !== 1'b1) begin
        if (sb.size() == 0) begin
          checks++; failures++;
          $display("FAIL unexpected_done div=%0d mod=%0d", div, mod);
        end else begin
          cur = sb.pop_front();
          have_cur = 1'b1;
          checks++;
          if (div !== cur.d) begin failures++; $display("FAIL div got=%0d exp=%0d", div, cur.d); end
          checks++;
          if (mod !== cur.m) begin failures++; $display("FAIL mod got=%0d exp=%0d", mod, cur.m); end
          checks++;
          if (edges != int'(cur.lat)) begin
            failures++; $display("FAIL latency got=%0d exp=%0d", edges, cur.lat);
          end
        end
      end else if (done === 1'b1) begin
        if (have_cur) begin
          checks++;
          if (div !== cur.d || mod !== cur.m) begin
            failures++;
            $display("FAIL hold got div=%0d mod=%0d exp div=%0d mod=%0d", div, mod, cur.d, cur.m);
          end
        end
      end else begin
        checks++;
        if (done !== 1'b0 || div !== 8'd0 || mod !== 8'd0) begin
          failures++;
          $display("FAIL idle_zero done=%b div=%0d mod=%0d exp 0/0/0", done, div, mod);
        end
      end
      done_q = done;
    end
  end

  // Pulse reset with (a,b), switch inputs to (a2,b2) after the LOAD edge, wait for done.
  task automatic run(input logic [7:0] a, input logic [7:0] b,
                     input logic [7:0] a2, input logic [7:0] b2,
                     input logic [7:0] ed, input logic [7:0] em);
    exp_t e;
    A = a; B = b; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    e.d = ed; e.m = em;
`ifdef DIV_ZERO_FAST_EN
    e.lat = (b == 8'd0) ? 8'd2 : 8'd9;
`else
    e.lat = 8'd9;
`endif
    sb.push_back(e);
    @(negedge clk);
    A = a2; B = b2;
    for (int i = 0; i < 20 && done !== 1'b1; i++) @(negedge clk);
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL timeout a=%0d b=%0d done=%b exp 1", a, b, done);
      sb.delete();
    end
    repeat (3) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1;
    repeat (3) @(negedge clk);
    checks++;
    if (done !== 1'b0 || div !== 8'd0 || mod !== 8'd0) begin
      failures++;
      $display("FAIL reset_state done=%b div=%0d mod=%0d exp 0/0/0", done, div, mod);
    end
    done_q = 1'b0;
    mon_en = 1'b1;

    run(8'd100, 8'd7,   8'd100, 8'd7,   8'd14,  8'd2);
    run(8'd255, 8'd1,   8'd255, 8'd1,   8'd255, 8'd0);
    run(8'd0,   8'd200, 8'd0,   8'd200, 8'd0,   8'd0);
    run(8'd5,   8'd255, 8'd5,   8'd255, 8'd0,   8'd5);
    run(8'd254, 8'd255, 8'd254, 8'd255, 8'd0,   8'd254);
    run(8'd255, 8'd128, 8'd255, 8'd128, 8'd1,   8'd127);
    run(8'd255, 8'd255, 8'd255, 8'd255, 8'd1,   8'd0);
    run(8'd171, 8'd170, 8'd171, 8'd170, 8'd1,   8'd1);
    run(8'd128, 8'd2,   8'd128, 8'd2,   8'd64,  8'd0);
    run(8'd255, 8'd16,  8'd255, 8'd16,  8'd15,  8'd15);

    // Inputs changed after the LOAD edge must be ignored.
    run(8'd77,  8'd10,  8'd1,   8'd10,  8'd7,   8'd7);
    run(8'd200, 8'd13,  8'd3,   8'd99,  8'd15,  8'd5);

    // Abort A=200,B=3 at its 4th iteration, then restart with A=9,B=4.
    A = 8'd200; B = 8'd3; reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    repeat (4) @(negedge clk);
    run(8'd9, 8'd4, 8'd9, 8'd4, 8'd2, 8'd1);

    // Held reset keeps everything cleared, then a normal run.
    A = 8'd50; B = 8'd6; reset = 1'b1;
    repeat (4) @(negedge clk);
    run(8'd50, 8'd6, 8'd50, 8'd6, 8'd8, 8'd2);

    // Zero divisor.
    run(8'd42, 8'd0, 8'd42, 8'd0, 8'd255, 8'd42);
    run(8'd0,  8'd0, 8'd0,  8'd0, 8'd255, 8'd0);

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_leftover got=%0d exp=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
